// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned shift-and-add multiplier with valid/ready handshakes.
// Retires one multiplier bit per cycle and stops once the remaining multiplier bits are all zero.
module shift_add_multiplier #(
  parameter int MULTIPLICAND_WIDTH = 64,
  parameter int MULTIPLIER_WIDTH   = 32,
  parameter int PRODUCT_WIDTH      = MULTIPLICAND_WIDTH + MULTIPLIER_WIDTH
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_valid_i,
  output logic                          start_ready_o,
  input  logic [MULTIPLICAND_WIDTH-1:0] multiplicand_i,
  input  logic [MULTIPLIER_WIDTH-1:0]   multiplier_i,
  output logic                          product_valid_o,
  input  logic                          product_ready_i,
  output logic [PRODUCT_WIDTH-1:0]      product_o,
  output logic                          busy_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                        state_q, state_d;
  logic [PRODUCT_WIDTH-1:0]      acc_q, acc_d, mcand_q, mcand_d, product_q, product_d;
  logic [MULTIPLIER_WIDTH-1:0]   mplier_q, mplier_d;
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;
    case (state_q)
      IDLE: if (start_valid_i) begin
        acc_d    = '0;
        mcand_d  = PRODUCT_WIDTH'(multiplicand_i);
        mplier_d = multiplier_i;
        state_d  = RUN;
      end
      RUN: begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        // Result is captured on the final RUN edge so product_o holds through IDLE.
        if (mplier_d == '0) begin
          state_d   = DONE;
          product_d = acc_d;
        end
      end
      DONE: state_d = product_ready_i ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
    end
  end
  assign start_ready_o   = (state_q == IDLE) && !rst_i;
  assign product_valid_o = state_q == DONE;
  assign busy_o          = state_q != IDLE;
  assign product_o       = product_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: directed and randomized checks of the shift-add multiplier
// against a plain-arithmetic product and bit-length latency model.
module tb_shift_add_multiplier;
  logic        clk = 0, rst = 1;
  logic        start_valid = 0, start_ready, product_valid, product_ready = 0, busy;
  logic [63:0] multiplicand = '0;
  logic [31:0] multiplier = '0;
  logic [95:0] product;
  int          n_checks = 0, n_fail = 0;

  shift_add_multiplier dut (
    .clk_i(clk), .rst_i(rst), .start_valid_i(start_valid), .start_ready_o(start_ready),
    .multiplicand_i(multiplicand), .multiplier_i(multiplier), .product_valid_o(product_valid),
    .product_ready_i(product_ready), .product_o(product), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transaction: accept, count RUN edges to valid, optional backpressure, then release.
  task automatic run_op(input logic [63:0] a, input logic [31:0] b, input int bp, input bit hold);
    logic [95:0] exp;
    int          k, cnt;
    exp = 96'(a) * 96'(b);
    k = 1;
    for (int i = 0; i < 32; i++) if (b[i]) k = i + 1;
    @(negedge clk);
    check("ready_idle", start_ready, 1);
    start_valid = 1;
    multiplicand = a;
    multiplier = b;
    @(posedge clk);
    @(negedge clk);
    start_valid = hold;
    product_ready = hold;
    cnt = 0;
    while (!product_valid && cnt < 40) begin
      check("busy_run", busy, 1);
      check("ready_run", start_ready, 0);
      if (hold) begin
        multiplicand = {$urandom, $urandom};
        multiplier = $urandom;
      end
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
    check("latency", cnt, k);
    check("product", product, exp);
    check("busy_done", busy, 1);
    product_ready = 0;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_valid", product_valid, 1);
      check("bp_product", product, exp);
      check("bp_ready", start_ready, 0);
    end
    start_valid = 0;
    product_ready = 1;
    @(posedge clk);
    @(negedge clk);
    product_ready = 0;
    check("exit_valid", product_valid, 0);
    check("exit_busy", busy, 0);
    check("exit_ready", start_ready, 1);
    check("exit_product", product, exp);
  endtask

  initial begin
    logic [31:0] b;
    #1;
    check("rst_ready", start_ready, 0);
    check("rst_valid", product_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_product", product, 0);
    @(negedge clk);
    #2 rst = 0;
    #1 check("ready_after_rst", start_ready, 1);
    run_op(64'd10, 32'd2, 0, 0);
    run_op(64'd97813, 32'd135, 0, 0);
    run_op('1, '1, 0, 0);
    run_op(64'd74101, 32'd0, 0, 1);
    run_op(64'd74101, 32'd1, 0, 1);
    run_op(64'd0, 32'hF00F, 1, 0);
    run_op(64'd50, 32'd7, 10, 0);
    // Reset during RUN discards the in-flight operation.
    @(negedge clk);
    start_valid = 1;
    multiplicand = 64'd20;
    multiplier = 32'h8000_0000;
    @(posedge clk);
    @(negedge clk);
    start_valid = 0;
    repeat (4) @(posedge clk);
    #2 rst = 1;
    #1;
    check("mid_rst_valid", product_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_product", product, 0);
    check("mid_rst_ready", start_ready, 0);
    @(negedge clk);
    rst = 0;
    #1 check("ready_after_mid_rst", start_ready, 1);
    run_op(64'd30, 32'd4, 0, 0);
    for (int t = 0; t < 24; t++) begin
      b = $urandom >> $urandom_range(31, 0);
      run_op({$urandom, $urandom}, b, $urandom_range(3, 0), 1'($urandom));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
